// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one UART transmitter between two byte requesters
// (ch0 = guess/keypad path, ch1 = game-status path). Each byte is granted
// round-robin, latched, launched with a one-cycle strobe, and tracked
// through the UART busy window. The requester gets a one-cycle ack when
// its frame completes. A timeout aborts the frame and sets a sticky err.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | tx_byte parked at 8'hFF, arbitrate between req0/req1
// LATCH     | granted byte and channel are held, strobe launches next
// START     | tx_ctrl high for this single cycle, blue on, timer cleared
// WAIT_BUSY | waiting for the UART to raise tx_busy (START_TO limit)
// WAIT_DONE | frame in flight, waiting for tx_busy to fall (FRAME_TO limit)
// ACK       | one-cycle ack on the granted channel, blue off
// ABORT     | timeout: no ack, err set, other channel favoured next

module tx_arbiter #(
    parameter int START_TO = 16,
    parameter int FRAME_TO = 4096
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic       tx_busy,
    output logic       tx_ctrl,
    output logic [7:0] tx_byte,
    output logic       ack0,
    output logic       ack1,
    output logic       blue,
    output logic       err
);

    localparam int TW = $clog2(FRAME_TO);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LATCH     = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] ACK       = 3'd5;
    localparam logic [2:0] ABORT     = 3'd6;

    localparam logic [TW-1:0] START_LIM = TW'(START_TO - 1);
    localparam logic [TW-1:0] FRAME_LIM = TW'(FRAME_TO - 1);
    localparam logic [TW-1:0] TIMER_MAX = '1;

    logic [2:0]    r_state;
    logic          r_gnt;
    logic          r_last_grant;
    logic [TW-1:0] r_timer;
    logic          r_tx_ctrl;
    logic [7:0]    r_tx_byte;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_blue;
    logic          r_err;

    logic          w_any_req;
    logic          w_pick;
    logic [TW-1:0] w_timer_inc;

    // Round-robin pick: a lone request wins outright; on a tie the channel
    // that was not served last wins.
    always_comb begin
        w_any_req = req0 | req1;
        w_pick    = 1'b0;
        if (req0 && req1) begin
            w_pick = ~r_last_grant;
        end else begin
            w_pick = req1;
        end
        w_timer_inc = (r_timer == TIMER_MAX) ? r_timer : r_timer + 1'b1;
    end

    // Sequencer: every output is a register updated on the edge that
    // enters the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state      <= IDLE;
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_timer      <= '0;
            r_tx_ctrl    <= 1'b0;
            r_tx_byte    <= 8'hFF;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_blue       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_tx_ctrl <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx_byte <= 8'hFF;
                    if (w_any_req) begin
                        r_gnt     <= w_pick;
                        r_tx_byte <= w_pick ? data1 : data0;
                        r_state   <= LATCH;
                    end
                end
                LATCH: begin
                    r_tx_ctrl <= 1'b1;
                    r_blue    <= 1'b1;
                    r_timer   <= '0;
                    r_state   <= START;
                end
                START: begin
                    r_timer <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_timer <= '0;
                        r_state <= WAIT_DONE;
                    end else if (r_timer == START_LIM) begin
                        r_err        <= 1'b1;
                        r_blue       <= 1'b0;
                        r_last_grant <= r_gnt;
                        r_state      <= ABORT;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_ack0       <= ~r_gnt;
                        r_ack1       <= r_gnt;
                        r_blue       <= 1'b0;
                        r_last_grant <= r_gnt;
                        r_state      <= ACK;
                    end else if (r_timer == FRAME_LIM) begin
                        r_err        <= 1'b1;
                        r_blue       <= 1'b0;
                        r_last_grant <= r_gnt;
                        r_state      <= ABORT;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                ACK, ABORT: begin
                    r_tx_byte <= 8'hFF;
                    r_state   <= IDLE;
                end
                default: begin
                    r_tx_byte <= 8'hFF;
                    r_blue    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign tx_ctrl = r_tx_ctrl;
    assign tx_byte = r_tx_byte;
    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign blue    = r_blue;
    assign err     = r_err;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a small UART model answers the start
// strobe, and each scenario task checks hand-computed cycle positions.
// Cycle numbers below count clock edges from the cycle tx_ctrl is high.

module tb_tx_arbiter;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       req0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       req1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_ctrl;
    logic [7:0] tx_byte;
    logic       ack0;
    logic       ack1;
    logic       blue;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    // 0: busy 2 cycles after strobe for 10 cycles, 1: never busy,
    // 2: busy 1 cycle after strobe and stuck until mode changes
    int uart_mode = 0;

    tx_arbiter #(.START_TO(16), .FRAME_TO(64)) dut (
        .clk(clk), .nRst(nRst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .tx_busy(tx_busy), .tx_ctrl(tx_ctrl), .tx_byte(tx_byte),
        .ack0(ack0), .ack1(ack1), .blue(blue), .err(err)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (tx_ctrl === 1'b1 && uart_mode == 0) begin
            repeat (2) @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1 tx_busy = 1'b0;
        end else if (tx_ctrl === 1'b1 && uart_mode == 2) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            wait (uart_mode != 2);
            tx_busy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        uart_mode = 0;
        nRst = 1'b0;
        repeat (16) tick();
        nRst = 1'b1;
    endtask

    task automatic test_reset();
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
        n_vec++; if (tx_ctrl !== 1'b0) begin n_err++; $display("FAIL rst_tx_ctrl got=%0h exp=0", tx_ctrl); end
        n_vec++; if (tx_byte !== 8'hFF) begin n_err++; $display("FAIL rst_tx_byte got=%0h exp=ff", tx_byte); end
        n_vec++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL rst_acks got=%0b exp=00", {ack0, ack1}); end
        n_vec++; if (blue !== 1'b0) begin n_err++; $display("FAIL rst_blue got=%0h exp=0", blue); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%0h exp=0", err); end
    endtask

    task automatic test_single();
        int ack_k = -1;
        int n_a0 = 0, n_a1 = 0, n_strobe = 0;
        req0 = 1'b1; data0 = 8'h41;
        n_vec++; if (tx_byte !== 8'hFF) begin n_err++; $display("FAIL single_pre_byte got=%0h exp=ff", tx_byte); end
        tick();
        n_vec++; if (tx_ctrl !== 1'b0) begin n_err++; $display("FAIL single_early_strobe got=%0h exp=0", tx_ctrl); end
        tick();
        n_vec++; if (tx_ctrl !== 1'b1) begin n_err++; $display("FAIL single_strobe got=%0h exp=1", tx_ctrl); end
        n_vec++; if (tx_byte !== 8'h41) begin n_err++; $display("FAIL single_byte got=%0h exp=41", tx_byte); end
        n_vec++; if (blue !== 1'b1) begin n_err++; $display("FAIL single_blue got=%0h exp=1", blue); end
        // busy is high cycles 2..11, seen low at the end of 12, ack in 13
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (tx_ctrl === 1'b1) n_strobe++;
            if (ack1 === 1'b1) n_a1++;
            if (ack0 === 1'b1) begin
                n_a0++;
                if (ack_k < 0) ack_k = k;
                req0 = 1'b0;
            end
        end
        n_vec++; if (ack_k !== 13) begin n_err++; $display("FAIL single_ack_cycle got=%0d exp=13", ack_k); end
        n_vec++; if (n_a0 !== 1) begin n_err++; $display("FAIL single_ack0_count got=%0d exp=1", n_a0); end
        n_vec++; if (n_a1 !== 0) begin n_err++; $display("FAIL single_ack1_count got=%0d exp=0", n_a1); end
        n_vec++; if (n_strobe !== 0) begin n_err++; $display("FAIL single_extra_strobe got=%0d exp=0", n_strobe); end
        n_vec++; if (blue !== 1'b0) begin n_err++; $display("FAIL single_blue_end got=%0h exp=0", blue); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_byte [4];
        logic       exp_ch   [4];
        logic [7:0] got_byte [4];
        logic       got_ch   [4];
        int nb = 0, na = 0, k = 0, ack_at = -1, gap = -1, overlap = 0;
        exp_byte[0] = 8'h11; exp_byte[1] = 8'h22; exp_byte[2] = 8'h11; exp_byte[3] = 8'h22;
        exp_ch[0] = 1'b0; exp_ch[1] = 1'b1; exp_ch[2] = 1'b0; exp_ch[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin got_byte[i] = 8'h00; got_ch[i] = 1'b0; end
        req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
        do_reset();
        while (na < 4 && k < 200) begin
            tick();
            k++;
            if (tx_ctrl === 1'b1) begin
                if (nb < 4) got_byte[nb] = tx_byte;
                nb++;
                if (gap < 0 && ack_at >= 0) gap = k - ack_at;
            end
            if (ack0 === 1'b1 && ack1 === 1'b1) overlap++;
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                if (na < 4) got_ch[na] = ack1;
                na++;
                if (ack_at < 0) ack_at = k;
            end
        end
        n_vec++; if (na !== 4) begin n_err++; $display("FAIL cont_ack_count got=%0d exp=4", na); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (got_byte[i] !== exp_byte[i]) begin n_err++; $display("FAIL cont_byte[%0d] got=%0h exp=%0h", i, got_byte[i], exp_byte[i]); end
            n_vec++; if (got_ch[i] !== exp_ch[i]) begin n_err++; $display("FAIL cont_ack_ch[%0d] got=%0d exp=%0d", i, got_ch[i], exp_ch[i]); end
        end
        n_vec++; if (gap !== 3) begin n_err++; $display("FAIL cont_ack_to_strobe got=%0d exp=3", gap); end
        n_vec++; if (overlap !== 0) begin n_err++; $display("FAIL cont_ack_overlap got=%0d exp=0", overlap); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_start_timeout();
        int err_k = -1, k = 0, n_a1 = 0;
        req0 = 1'b0; req1 = 1'b1; data1 = 8'h33;
        do_reset();
        uart_mode = 1;
        tick();
        tick();
        n_vec++; if (tx_ctrl !== 1'b1) begin n_err++; $display("FAIL sto_strobe got=%0h exp=1", tx_ctrl); end
        n_vec++; if (tx_byte !== 8'h33) begin n_err++; $display("FAIL sto_byte got=%0h exp=33", tx_byte); end
        // WAIT_BUSY spans cycles 1..16; err shows in the ABORT cycle 17
        while (err_k < 0 && k < 40) begin
            tick();
            k++;
            if (ack1 === 1'b1) n_a1++;
            if (err === 1'b1) err_k = k;
        end
        n_vec++; if (err_k !== 17) begin n_err++; $display("FAIL sto_err_cycle got=%0d exp=17", err_k); end
        n_vec++; if (blue !== 1'b0) begin n_err++; $display("FAIL sto_blue got=%0h exp=0", blue); end
        req0 = 1'b1; data0 = 8'h44;
        tick();
        tick();
        if (ack1 === 1'b1) n_a1++;
        n_vec++; if (tx_byte !== 8'h44) begin n_err++; $display("FAIL sto_next_grant got=%0h exp=44", tx_byte); end
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL sto_err_sticky got=%0h exp=1", err); end
        n_vec++; if (n_a1 !== 0) begin n_err++; $display("FAIL sto_no_ack1 got=%0d exp=0", n_a1); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_frame_timeout();
        int err_k = -1, k = 0;
        req0 = 1'b1; data0 = 8'h55; req1 = 1'b0;
        do_reset();
        uart_mode = 2;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL fto_err_cleared got=%0h exp=0", err); end
        tick();
        tick();
        n_vec++; if (tx_ctrl !== 1'b1) begin n_err++; $display("FAIL fto_strobe got=%0h exp=1", tx_ctrl); end
        // WAIT_DONE entered in cycle 2 and occupies 64 cycles, err in 66
        while (err_k < 0 && k < 100) begin
            tick();
            k++;
            if (err === 1'b1) err_k = k;
        end
        n_vec++; if (err_k !== 66) begin n_err++; $display("FAIL fto_err_cycle got=%0d exp=66", err_k); end
        tick();
        req0 = 1'b0;
        n_vec++; if (tx_byte !== 8'hFF) begin n_err++; $display("FAIL fto_idle_byte got=%0h exp=ff", tx_byte); end
        n_vec++; if (blue !== 1'b0) begin n_err++; $display("FAIL fto_idle_blue got=%0h exp=0", blue); end
        repeat (5) tick();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL fto_err_sticky got=%0h exp=1", err); end
        uart_mode = 0;
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL fto_err_reset got=%0h exp=0", err); end
    endtask

    task automatic test_mid_reset();
        req0 = 1'b1; data0 = 8'h66; req1 = 1'b1; data1 = 8'h77;
        do_reset();
        tick();
        tick();
        n_vec++; if (tx_byte !== 8'h66) begin n_err++; $display("FAIL mid_first_byte got=%0h exp=66", tx_byte); end
        repeat (4) tick();
        n_vec++; if (blue !== 1'b1) begin n_err++; $display("FAIL mid_in_flight got=%0h exp=1", blue); end
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        n_vec++; if (tx_byte !== 8'hFF) begin n_err++; $display("FAIL mid_byte got=%0h exp=ff", tx_byte); end
        n_vec++; if (blue !== 1'b0) begin n_err++; $display("FAIL mid_blue got=%0h exp=0", blue); end
        n_vec++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL mid_acks got=%0b exp=00", {ack0, ack1}); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err got=%0h exp=0", err); end
        tick();
        n_vec++; if (tx_byte !== 8'h66) begin n_err++; $display("FAIL mid_tie_ch0 got=%0h exp=66", tx_byte); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_early_drop();
        int ack_k = -1, n_a0 = 0, n_a1 = 0;
        logic [7:0] ack_byte = 8'h00;
        req0 = 1'b1; data0 = 8'h41; req1 = 1'b0;
        do_reset();
        tick();
        tick();
        req0 = 1'b0; data0 = 8'h00;
        n_vec++; if (tx_ctrl !== 1'b1) begin n_err++; $display("FAIL drop_strobe got=%0h exp=1", tx_ctrl); end
        n_vec++; if (tx_byte !== 8'h41) begin n_err++; $display("FAIL drop_byte got=%0h exp=41", tx_byte); end
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ack1 === 1'b1) n_a1++;
            if (ack0 === 1'b1) begin
                n_a0++;
                if (ack_k < 0) begin ack_k = k; ack_byte = tx_byte; end
            end
        end
        n_vec++; if (ack_k !== 13) begin n_err++; $display("FAIL drop_ack_cycle got=%0d exp=13", ack_k); end
        n_vec++; if (ack_byte !== 8'h41) begin n_err++; $display("FAIL drop_byte_held got=%0h exp=41", ack_byte); end
        n_vec++; if (n_a0 !== 1) begin n_err++; $display("FAIL drop_ack0_count got=%0d exp=1", n_a0); end
        n_vec++; if (n_a1 !== 0) begin n_err++; $display("FAIL drop_ack1_count got=%0d exp=0", n_a1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_start_timeout();
        test_frame_timeout();
        test_mid_reset();
        test_early_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
